rom_fetch: RTL and testbench
============================

ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 SHALL provide Clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL provide nReset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide CPUAddr  in  17  mapped PRG byte address from the mapper stage.
REQ-004 SHALL provide CPU_Rd  in  1  one-cycle PRG read strobe.
REQ-005 SHALL provide PPUAddr  in  17  mapped CHR byte address from the mapper stage.
REQ-006 SHALL provide PPU_Rd  in  1  one-cycle CHR read strobe.
REQ-007 SHALL provide PPU_Wr  in  1  one-cycle CHR write strobe; honoured only when useCHRram=1.
REQ-008 SHALL provide PPU_WrData  in  8  CHR write byte.
REQ-009 SHALL provide useCHRram  in  1  selects the CHR-RAM region for PPU accesses.
REQ-010 SHALL provide mem_req  out  1  memory request, held until acknowledged.
REQ-011 SHALL provide mem_addr  out  19  memory byte address.
REQ-012 SHALL provide mem_we  out  1  write qualifier for mem_req.
REQ-013 SHALL provide mem_wdata  out  8  write byte.
REQ-014 SHALL provide mem_ack  in  1  one-cycle completion; rdata valid in the same cycle.
REQ-015 SHALL provide mem_rdata  in  8  read byte.
REQ-016 SHALL provide CPU_Data / PPU_Data  out  8 each  registered returned bytes.
REQ-017 SHALL provide CPU_Valid / PPU_Valid  out  1 each  one-cycle completion pulses; PPU_Valid also pulses on write completion.
REQ-018 SHALL provide Busy  out  1  high while a memory access is in flight.

Function
REQ-019 SHALL map addresses as follows: PRG = {2'b00,CPUAddr}; CHR-ROM = 19'h20000+PPUAddr; CHR-RAM = 19'h40000+PPUAddr[12:0].
REQ-020 SHALL give each port a one-entry pending slot (address, type); a strobe on a port loads its slot.
REQ-021 SHALL, when a strobe arrives while the slot is already pending and not yet issued, overwrite the slot (newest wins, one completion).
REQ-022 SHALL use the FSM IDLE -> ISSUE -> IDLE: IDLE grants a pending slot and asserts mem_req on the next cycle; ISSUE holds mem_req/addr/we/wdata stable until mem_ack, then returns to IDLE.
REQ-023 SHALL capture mem_rdata on the mem_ack cycle and pulse the matching Valid exactly one cycle later.
REQ-024 SHALL arbitrate with PPU priority, except that after 2 consecutive PPU grants with CPU pending the CPU is granted; any CPU grant clears the counter.
REQ-025 SHALL accept and register a strobe to the in-flight port into that port's slot during ISSUE; it is serviced afterwards.
REQ-026 SHALL complete simultaneous CPU_Rd and PPU_Rd in IDLE as PPU first, then CPU.
REQ-027 SHALL treat PPU_Wr with useCHRram=0 as a no-op: no memory request and no Valid.
REQ-028 SHALL give PPU_Wr priority over PPU_Rd when both are asserted in the same cycle.
REQ-029 SHALL make minimum strobe-to-Valid latency 3 cycles when mem_ack arrives on the first mem_req cycle.

Reset
REQ-030 SHALL, on nReset low (asynchronous), force FSM=IDLE, clear both slots and the fairness counter, and set mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, CPU_Data=0, PPU_Data=0, Valid=0 and Busy=0.
REQ-031 SHALL, after reset asserts mid-ISSUE, produce no Valid for the aborted access; a late mem_ack in IDLE is ignored.

Configuration
REQ-032 SHALL, with ROM_FETCH_CACHE_EN defined, hold one cached PRG {address, byte, valid} entry; a CPU_Rd hitting it pulses CPU_Valid one cycle later with no memory request; the cache is filled on each PRG ack and invalidated on reset.
REQ-033 SHALL, with ROM_FETCH_CACHE_EN undefined, send every CPU_Rd to memory, and its behaviour SHALL otherwise be identical.

Verification
REQ-034 The bench SHALL cover: CPU_Rd with CPUAddr=17'h01234 and ack on the first cycle -> mem_addr=19'h01234, CPU_Valid 3 cycles after the strobe, CPU_Data=mem_rdata.
REQ-035 The bench SHALL cover: CPU_Rd and PPU_Rd in the same cycle with PPUAddr=17'h00010 -> first mem_addr=19'h20010, then CPU access, two Valid pulses in order.
REQ-036 The bench SHALL cover: CPU pending plus continuous PPU_Rd -> grants in the order PPU, PPU, CPU.
REQ-037 The bench SHALL cover: PPU_Wr with useCHRram=1, PPUAddr=17'h1FFF, data 8'hA5 -> mem_we=1, mem_addr=19'h41FFF, mem_wdata=8'hA5, PPU_Valid pulse; with useCHRram=0 -> no mem_req.
REQ-038 The bench SHALL cover: nReset low while mem_req=1 and ack withheld -> all outputs 0 immediately, no Valid after release, late ack ignored.
REQ-039 The bench SHALL cover, with ROM_FETCH_CACHE_EN: two CPU_Rd to 17'h00042 -> one mem_req, and the second CPU_Valid 1 cycle after its strobe.

Source files
------------

// File: rtl/rom_fetch.sv
// PRG/CHR fetch arbiter: one pending slot per port, PPU-priority with CPU fairness.
// Define ROM_FETCH_CACHE_EN to add a single-entry PRG byte cache in front of memory.
module rom_fetch (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [16:0] CPUAddr,
    input  logic        CPU_Rd,
    input  logic [16:0] PPUAddr,
    input  logic        PPU_Rd,
    input  logic        PPU_Wr,
    input  logic [7:0]  PPU_WrData,
    input  logic        useCHRram,
    output logic        mem_req,
    output logic [18:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  CPU_Data,
    output logic [7:0]  PPU_Data,
    output logic        CPU_Valid,
    output logic        PPU_Valid,
    output logic        Busy
);

    localparam logic [18:0] CHR_ROM_BASE = 19'h20000;
    localparam logic [18:0] CHR_RAM_BASE = 19'h40000;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t      state_reg;
    logic        cpu_pend_reg;
    logic [16:0] cpu_addr_reg;
    logic        ppu_pend_reg;
    logic [18:0] ppu_addr_reg;
    logic        ppu_we_reg;
    logic [7:0]  ppu_wdata_reg;
    logic [1:0]  streak_reg;
    logic        cur_ppu_reg;

    logic        ppu_wr_eff;
    logic        ppu_strobe;
    logic [18:0] chr_addr;
    logic        grant_cpu;
    logic        grant_ppu;

    // A CHR write without CHR-RAM is dropped before it can reach the slot.
    assign ppu_wr_eff = PPU_Wr && useCHRram;
    assign ppu_strobe = ppu_wr_eff || PPU_Rd;
    assign chr_addr   = useCHRram ? (CHR_RAM_BASE + {6'd0, PPUAddr[12:0]})
                                  : (CHR_ROM_BASE + {2'd0, PPUAddr});

    assign grant_cpu = cpu_pend_reg && (!ppu_pend_reg || streak_reg == 2'd2);
    assign grant_ppu = ppu_pend_reg && !grant_cpu;

`ifdef ROM_FETCH_CACHE_EN
    logic        cache_valid_reg;
    logic [16:0] cache_addr_reg;
    logic [7:0]  cache_data_reg;
    logic        cache_hit;

    // A hit cannot share the CPU_Valid cycle with a memory completion; it falls back to the slot.
    assign cache_hit = CPU_Rd && cache_valid_reg && (cache_addr_reg == CPUAddr)
                       && !(state_reg == S_ISSUE && mem_ack && !cur_ppu_reg);
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_reg     <= S_IDLE;
            cpu_pend_reg  <= 1'b0;
            cpu_addr_reg  <= 17'd0;
            ppu_pend_reg  <= 1'b0;
            ppu_addr_reg  <= 19'd0;
            ppu_we_reg    <= 1'b0;
            ppu_wdata_reg <= 8'd0;
            streak_reg    <= 2'd0;
            cur_ppu_reg   <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= 19'd0;
            mem_we        <= 1'b0;
            mem_wdata     <= 8'd0;
            CPU_Data      <= 8'd0;
            PPU_Data      <= 8'd0;
            CPU_Valid     <= 1'b0;
            PPU_Valid     <= 1'b0;
            Busy          <= 1'b0;
`ifdef ROM_FETCH_CACHE_EN
            cache_valid_reg <= 1'b0;
            cache_addr_reg  <= 17'd0;
            cache_data_reg  <= 8'd0;
`endif
        end else begin
            CPU_Valid <= 1'b0;
            PPU_Valid <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (grant_cpu) begin
                        state_reg    <= S_ISSUE;
                        mem_req      <= 1'b1;
                        Busy         <= 1'b1;
                        mem_addr     <= {2'b00, cpu_addr_reg};
                        mem_we       <= 1'b0;
                        mem_wdata    <= 8'd0;
                        cur_ppu_reg  <= 1'b0;
                        cpu_pend_reg <= 1'b0;
                        streak_reg   <= 2'd0;
                    end else if (grant_ppu) begin
                        state_reg    <= S_ISSUE;
                        mem_req      <= 1'b1;
                        Busy         <= 1'b1;
                        mem_addr     <= ppu_addr_reg;
                        mem_we       <= ppu_we_reg;
                        mem_wdata    <= ppu_wdata_reg;
                        cur_ppu_reg  <= 1'b1;
                        ppu_pend_reg <= 1'b0;
                        // Only PPU grants that made the CPU wait count towards fairness.
                        streak_reg   <= cpu_pend_reg ? (streak_reg + 2'd1) : 2'd0;
                    end
                end
                S_ISSUE: begin
                    if (mem_ack) begin
                        state_reg <= S_IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        Busy      <= 1'b0;
                        if (cur_ppu_reg) begin
                            PPU_Valid <= 1'b1;
                            if (!mem_we) begin
                                PPU_Data <= mem_rdata;
                            end
                        end else begin
                            CPU_Valid <= 1'b1;
                            CPU_Data  <= mem_rdata;
`ifdef ROM_FETCH_CACHE_EN
                            cache_valid_reg <= 1'b1;
                            cache_addr_reg  <= mem_addr[16:0];
                            cache_data_reg  <= mem_rdata;
`endif
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // Strobes are taken after the grant so a new request refills a just-issued slot.
`ifdef ROM_FETCH_CACHE_EN
            if (cache_hit) begin
                CPU_Valid    <= 1'b1;
                CPU_Data     <= cache_data_reg;
                cpu_pend_reg <= 1'b0;
            end else
`endif
            if (CPU_Rd) begin
                cpu_pend_reg <= 1'b1;
                cpu_addr_reg <= CPUAddr;
            end

            if (ppu_strobe) begin
                ppu_pend_reg  <= 1'b1;
                ppu_addr_reg  <= chr_addr;
                ppu_we_reg    <= ppu_wr_eff;
                ppu_wdata_reg <= PPU_WrData;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch.sv
// Directed bench for rom_fetch: a memory responder, a per-cycle rule checker and
// transaction logs that directed tests compare against hand-computed values.
module tb_rom_fetch;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic [16:0] CPUAddr = '0;
    logic        CPU_Rd = 1'b0;
    logic [16:0] PPUAddr = '0;
    logic        PPU_Rd = 1'b0;
    logic        PPU_Wr = 1'b0;
    logic [7:0]  PPU_WrData = '0;
    logic        useCHRram = 1'b0;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  CPU_Data;
    logic [7:0]  PPU_Data;
    logic        CPU_Valid;
    logic        PPU_Valid;
    logic        Busy;

    rom_fetch dut (
        .Clk(Clk), .nReset(nReset),
        .CPUAddr(CPUAddr), .CPU_Rd(CPU_Rd),
        .PPUAddr(PPUAddr), .PPU_Rd(PPU_Rd), .PPU_Wr(PPU_Wr),
        .PPU_WrData(PPU_WrData), .useCHRram(useCHRram),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .CPU_Data(CPU_Data), .PPU_Data(PPU_Data),
        .CPU_Valid(CPU_Valid), .PPU_Valid(PPU_Valid), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents: a fixed function of the byte address.
    function automatic logic [7:0] memf(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
    endfunction

    logic [47:0] outs;
    assign outs = {mem_req, mem_addr, mem_we, mem_wdata, CPU_Data, PPU_Data,
                   CPU_Valid, PPU_Valid, Busy};

    // Memory responder: acks after ack_delay extra cycles of mem_req.
    int   ack_delay = 0;
    int   age = 0;
    logic ack_hold = 1'b0;
    logic force_ack = 1'b0;
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge Clk);
            #2;
            if (force_ack) begin
                mem_ack = 1'b1;
                mem_rdata = 8'hEE;
            end else if (mem_req && !ack_hold) begin
                if (age >= ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = memf(mem_addr);
                    age = 0;
                end else begin
                    mem_ack = 1'b0;
                    age++;
                end
            end else begin
                mem_ack = 1'b0;
                age = 0;
            end
        end
    end

    // Transaction logs.
    logic [18:0] g_addr [64];
    logic        g_we   [64];
    logic [7:0]  g_wd   [64];
    int          g_n = 0;
    logic        c_port [64];
    logic [7:0]  c_data [64];
    int          c_cyc  [64];
    int          c_n = 0;

    // Per-cycle rules: Valid follows an accepted ack by one cycle with the acked byte,
    // Busy tracks an outstanding request, and a request is held stable until acked.
    logic        p_req = 1'b0, p_ack = 1'b0, p_cpu = 1'b0, p_ppu = 1'b0, p_we = 1'b0;
    logic [18:0] p_addr = '0;
    logic [7:0]  p_wd = '0, p_data = '0;
    always @(negedge Clk) begin
        if (!nReset) begin
            p_req = 1'b0; p_ack = 1'b0; p_cpu = 1'b0; p_ppu = 1'b0;
        end else begin
`ifdef ROM_FETCH_CACHE_EN
            if (p_cpu) chk("cpu_valid_after_ack", CPU_Valid, 1);
`else
            chk("cpu_valid", CPU_Valid, p_cpu);
`endif
            if (p_cpu) chk("cpu_data", CPU_Data, p_data);
            chk("ppu_valid", PPU_Valid, p_ppu);
            if (p_ppu && !p_we) chk("ppu_data", PPU_Data, p_data);
            chk("busy", Busy, mem_req);
            if (p_req && !p_ack) begin
                chk("req_hold", mem_req, 1);
                chk("req_stable", {mem_we, mem_wdata, mem_addr}, {p_we, p_wd, p_addr});
            end
            if (CPU_Valid && c_n < 64) begin
                c_port[c_n] = 1'b0; c_data[c_n] = CPU_Data; c_cyc[c_n] = cyc; c_n++;
            end
            if (PPU_Valid && c_n < 64) begin
                c_port[c_n] = 1'b1; c_data[c_n] = PPU_Data; c_cyc[c_n] = cyc; c_n++;
            end
            p_ack  = mem_req && mem_ack;
            p_cpu  = p_ack && (mem_addr[18:17] == 2'b00);
            p_ppu  = p_ack && (mem_addr[18:17] != 2'b00);
            p_data = mem_rdata;
            p_req  = mem_req;
            p_addr = mem_addr;
            p_we   = mem_we;
            p_wd   = mem_wdata;
            if (p_ack && g_n < 64) begin
                g_addr[g_n] = mem_addr; g_we[g_n] = mem_we; g_wd[g_n] = mem_wdata; g_n++;
            end
        end
    end

    int s_cyc = 0;

    task automatic drive(input logic crd, input logic [16:0] ca, input logic prd, input logic pwr,
                         input logic [16:0] pa, input logic [7:0] wd, input logic ram);
        @(posedge Clk);
        #1;
        CPU_Rd = crd; CPUAddr = ca;
        PPU_Rd = prd; PPU_Wr = pwr; PPUAddr = pa; PPU_WrData = wd; useCHRram = ram;
        s_cyc = cyc;
    endtask

    task automatic idle();
        @(posedge Clk);
        #1;
        CPU_Rd = 1'b0; PPU_Rd = 1'b0; PPU_Wr = 1'b0;
    endtask

    task automatic wait_cpl(input int n, input int budget, input string name);
        int k = 0;
        while (c_n < n && k < budget) begin
            @(posedge Clk);
            k++;
        end
        chk(name, (c_n >= n), 1);
    endtask

    int b, gb, s1, k;

    initial begin
        @(negedge Clk);
        chk("reset_outputs", outs, 48'd0);
        @(posedge Clk);
        #1 nReset = 1'b1;

        // Single PRG read, ack on first request cycle.
        ack_delay = 0; b = c_n; gb = g_n;
        drive(1, 17'h01234, 0, 0, 17'h0, 8'h0, 0); s1 = s_cyc;
        idle();
        wait_cpl(b + 1, 20, "t1_wait");
        chk("t1_addr", g_addr[gb], 19'h01234);
        chk("t1_port", c_port[b], 0);
        chk("t1_latency", c_cyc[b] - s1, 3);
        chk("t1_data", c_data[b], 8'h26);
        $display("[TB] t1 PRG read addr=%h data=%h", g_addr[gb], c_data[b]);

        // Simultaneous CPU and PPU reads: PPU first.
        b = c_n; gb = g_n;
        drive(1, 17'h00100, 1, 0, 17'h00010, 8'h0, 0); s1 = s_cyc;
        idle();
        wait_cpl(b + 2, 30, "t2_wait");
        chk("t2_first_addr", g_addr[gb], 19'h20010);
        chk("t2_second_addr", g_addr[gb + 1], 19'h00100);
        chk("t2_order", {c_port[b], c_port[b + 1]}, 2'b10);
        chk("t2_data", {c_data[b], c_data[b + 1]}, 16'h1201);
        chk("t2_latency", {c_cyc[b] - s1, c_cyc[b + 1] - s1}, {32'd3, 32'd5});
        $display("[TB] t2 dual read first=%h second=%h", g_addr[gb], g_addr[gb + 1]);

        // CPU pending under continuous PPU reads: PPU, PPU, CPU.
        b = c_n; gb = g_n;
        drive(1, 17'h00200, 1, 0, 17'h00300, 8'h0, 0);
        for (int i = 0; i < 6; i++) drive(0, 17'h0, 1, 0, 17'h00300, 8'h0, 0);
        idle();
        repeat (15) @(posedge Clk);
        chk("t3_grants_seen", (g_n >= gb + 3), 1);
        chk("t3_grant_order", {g_addr[gb], g_addr[gb + 1], g_addr[gb + 2]},
            {19'h20300, 19'h20300, 19'h00200});
        $display("[TB] t3 fairness grants %h %h %h", g_addr[gb], g_addr[gb + 1], g_addr[gb + 2]);

        // Strobes during ISSUE: newest CPU request wins, one completion.
        ack_delay = 3; b = c_n; gb = g_n;
        drive(0, 17'h0, 1, 0, 17'h00005, 8'h0, 0);
        idle();
        drive(1, 17'h00400, 0, 0, 17'h0, 8'h0, 0);
        drive(1, 17'h00401, 0, 0, 17'h0, 8'h0, 0);
        idle();
        wait_cpl(b + 2, 40, "t4_wait");
        repeat (6) @(posedge Clk);
        chk("t4_addrs", {g_addr[gb], g_addr[gb + 1]}, {19'h20005, 19'h00401});
        chk("t4_data", {c_port[b], c_data[b], c_port[b + 1], c_data[b + 1]},
            {1'b1, 8'h07, 1'b0, 8'h05});
        chk("t4_one_cpu", {g_n - gb, c_n - b}, {32'd2, 32'd2});
        $display("[TB] t4 overwrite cpu addr=%h data=%h", g_addr[gb + 1], c_data[b + 1]);

        // CHR-RAM write, then dropped write, then write beating a read.
        ack_delay = 1; b = c_n; gb = g_n;
        drive(0, 17'h0, 0, 1, 17'h01FFF, 8'hA5, 1);
        idle();
        wait_cpl(b + 1, 20, "t5_wait");
        chk("t5_write", {g_addr[gb], g_we[gb], g_wd[gb]}, {19'h41FFF, 1'b1, 8'hA5});
        chk("t5_port", c_port[b], 1);
        drive(0, 17'h0, 0, 1, 17'h01FFF, 8'h5A, 0);
        idle();
        repeat (8) @(posedge Clk);
        chk("t5_rom_write_dropped", {g_n - gb, c_n - b}, {32'd1, 32'd1});
        drive(0, 17'h0, 1, 1, 17'h00020, 8'h3C, 1);
        idle();
        wait_cpl(b + 2, 20, "t5_wr_rd_wait");
        repeat (6) @(posedge Clk);
        chk("t5_wr_over_rd", {g_n - gb, g_addr[gb + 1], g_we[gb + 1], g_wd[gb + 1]},
            {32'd2, 19'h40020, 1'b1, 8'h3C});
        useCHRram = 1'b0;
        $display("[TB] t5 chr-ram writes addr=%h addr=%h", g_addr[gb], g_addr[gb + 1]);

        // Reset during an unacknowledged request; late ack afterwards.
        ack_delay = 0; ack_hold = 1'b1; b = c_n; gb = g_n;
        drive(1, 17'h00777, 0, 0, 17'h0, 8'h0, 0);
        idle();
        k = 0;
        while (!mem_req && k < 10) begin
            @(posedge Clk);
            k++;
        end
        #1;
        chk("t6_req_up", mem_req, 1);
        @(posedge Clk);
        #1 nReset = 1'b0;
        #1;
        chk("t6_async_clear", outs, 48'd0);
        repeat (2) @(posedge Clk);
        #1;
        nReset = 1'b1;
        force_ack = 1'b1;
        @(posedge Clk);
        #1;
        force_ack = 1'b0;
        ack_hold = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        chk("t6_nothing_after", {g_n - gb, c_n - b, 31'd0, mem_req}, 96'd0);
        $display("[TB] t6 reset abort grants=%0d completions=%0d", g_n - gb, c_n - b);

`ifdef ROM_FETCH_CACHE_EN
        // Repeated PRG read served from the cache.
        ack_delay = 0; b = c_n; gb = g_n;
        drive(1, 17'h00042, 0, 0, 17'h0, 8'h0, 0);
        idle();
        wait_cpl(b + 1, 20, "t7_fill_wait");
        repeat (3) @(posedge Clk);
        drive(1, 17'h00042, 0, 0, 17'h0, 8'h0, 0); s1 = s_cyc;
        idle();
        wait_cpl(b + 2, 10, "t7_hit_wait");
        repeat (4) @(posedge Clk);
        chk("t7_hit_latency", c_cyc[b + 1] - s1, 1);
        chk("t7_hit_data", c_data[b + 1], 8'h42);
        chk("t7_one_request", g_n - gb, 1);
        $display("[TB] t7 cache hit data=%h", c_data[b + 1]);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
